// File: rtl/digest_hex_uart_tx.sv
// digest_hex_uart_tx
// Streams a captured 256-bit SHA-256 digest over an 8N1 UART line as 64
// lowercase hex characters (most significant nibble first) followed by
// CR LF. Characters are sent back-to-back with no idle gap between frames.
module digest_hex_uart_tx #(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         digest_valid,
    input  logic [255:0] digest,
    output logic         digest_ready,
    output logic         uart_tx,
    output logic         busy,
    output logic         done
);

    // Bit period in clock cycles; the done pulse timing needs at least 2.
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PENULT = CNT_W'(CLKS_PER_BIT - 2);

    // Character 64 is CR, character 65 is LF and the last of the message.
    localparam logic [6:0] CR_CHAR   = 7'd64;
    localparam logic [6:0] LAST_CHAR = 7'd65;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state;
    logic [255:0]        shadow;
    logic [6:0]          char_idx;
    logic [2:0]          bit_idx;
    logic [CNT_W-1:0]    baud_cnt;
    logic [7:0]          tx_byte;

    logic [6:0]          next_idx;
    logic [7:0]          next_char;
    logic [7:0]          first_char;
    logic                baud_end;

    // ASCII code of message character idx for digest d: hex nibbles for
    // 0..63 (digest[255:252] first), then CR, then LF.
    function automatic logic [7:0] char_for(input logic [255:0] d,
                                            input logic [6:0]   idx);
        logic [8:0] amt;
        logic [3:0] nib;
        amt = {7'(7'd63 - idx), 2'b00};
        nib = 4'(d >> amt);
        if (idx == CR_CHAR) begin
            char_for = 8'h0D;
        end else if (idx == LAST_CHAR) begin
            char_for = 8'h0A;
        end else if (nib < 4'd10) begin
            char_for = 8'h30 + {4'h0, nib};
        end else begin
            char_for = 8'h57 + {4'h0, nib};   // 'a' - 10
        end
    endfunction

    // Look-ahead of the next character to load and the bit-period boundary.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no
        // latch can be inferred.
        next_idx   = 7'(char_idx + 7'd1);
        next_char  = char_for(shadow, next_idx);
        first_char = char_for(digest, 7'd0);
        baud_end   = (baud_cnt == BAUD_LAST);
    end

    // Transmit FSM: capture, framing, character sequencing and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            // NOTE: the 256-bit shadow is ordinary flops, not a RAM, so it is
            // cleared with the rest of the state.
            shadow       <= '0;
            char_idx     <= '0;
            bit_idx      <= '0;
            baud_cnt     <= '0;
            tx_byte      <= '0;
            uart_tx      <= 1'b1;
            digest_ready <= 1'b1;
            done         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge state regardless of statement order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (digest_valid) begin
                        shadow       <= digest;
                        tx_byte      <= first_char;
                        char_idx     <= '0;
                        bit_idx      <= '0;
                        baud_cnt     <= '0;
                        uart_tx      <= 1'b0;
                        digest_ready <= 1'b0;
                        state        <= START;
                    end
                end

                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_tx  <= tx_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= tx_byte[3'(bit_idx + 3'd1)];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (char_idx == LAST_CHAR) begin
                            digest_ready <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            char_idx <= next_idx;
                            tx_byte  <= next_char;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        // Registered so that it lands on the final LF stop cycle.
                        if (char_idx == LAST_CHAR && baud_cnt == BAUD_PENULT) begin
                            done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state        <= IDLE;
                    uart_tx      <= 1'b1;
                    digest_ready <= 1'b1;
                end
            endcase
        end
    end

    // Busy is the exact complement of ready.
    assign busy = ~digest_ready;

endmodule
